// File: rtl/serpent_xts_sector_ctrl.sv
// Sequences one shared Serpent core through an XTS-mode sector encrypt (tweak, then whitened data blocks).
// Latency: tweak = core latency + 1; per block = 3 cycles + core latency; done pulse 1 cycle after last output.
// Backpressure: holds ciphertext on o_blk_valid until i_blk_ready; waits in BLK_IN for plaintext; one core request at a time.
module serpent_xts_sector_ctrl #(
    parameter int unsigned BLOCKS_PER_SECTOR = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic [127:0] i_sector,
    input  logic [255:0] i_key1,
    input  logic [255:0] i_key2,
    input  logic         i_abort,
    output logic         o_busy,
    output logic         o_sector_done,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [127:0] i_blk_data,
    output logic         o_blk_valid,
    input  logic         i_blk_ready,
    output logic [127:0] o_blk_data,
    output logic         o_core_key_valid,
    output logic         o_core_enable,
    output logic [255:0] o_core_key,
    output logic [127:0] o_core_data,
    input  logic [127:0] i_core_data,
    input  logic         i_core_valid
);

    typedef enum logic [2:0] {
        IDLE, TWK_REQ, TWK_WAIT, BLK_IN, BLK_REQ, BLK_WAIT, BLK_OUT, DONE
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(BLOCKS_PER_SECTOR);

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  sector;
    logic [255:0]  key1;
    logic [255:0]  key2;
    logic [127:0]  t;
    logic [127:0]  x;
    logic [127:0]  c;
    logic [15:0]   cnt;

    logic          twk_phase;
    logic          blk_phase;

    // IEEE 1619 tweak advance: multiply by alpha in GF(2^128), little-endian byte order.
    function automatic logic [127:0] mul_alpha(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    assign twk_phase = (state == TWK_REQ) || (state == TWK_WAIT);
    assign blk_phase = (state == BLK_REQ) || (state == BLK_WAIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; abort overrides every transition.
    always_comb begin
        state_nxt        = state;
        o_busy           = 1'b1;
        o_sector_done    = 1'b0;
        o_blk_ready      = 1'b0;
        o_blk_valid      = 1'b0;
        o_blk_data       = 128'h0;
        o_core_key_valid = 1'b0;
        o_core_enable    = 1'b0;
        o_core_key       = 256'h0;
        o_core_data      = 128'h0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = TWK_REQ;
            end
            TWK_REQ, TWK_WAIT: begin
                o_core_key_valid = 1'b1;
                o_core_enable    = 1'b1;
                o_core_key       = key2;
                o_core_data      = sector;
                if (i_core_valid)          state_nxt = BLK_IN;
                else if (state == TWK_REQ) state_nxt = TWK_WAIT;
            end
            BLK_IN: begin
                o_blk_ready = 1'b1;
                if (i_blk_valid) state_nxt = BLK_REQ;
            end
            BLK_REQ, BLK_WAIT: begin
                o_core_key_valid = 1'b1;
                o_core_enable    = 1'b1;
                o_core_key       = key1;
                o_core_data      = x;
                if (i_core_valid)          state_nxt = BLK_OUT;
                else if (state == BLK_REQ) state_nxt = BLK_WAIT;
            end
            BLK_OUT: begin
                o_blk_valid = 1'b1;
                o_blk_data  = c;
                if (i_blk_ready) state_nxt = ((cnt + 16'd1) == LAST_CNT) ? DONE : BLK_IN;
            end
            DONE: begin
                o_sector_done = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (i_abort && (state != IDLE)) state_nxt = IDLE;
        if (i_abort && (state == IDLE)) state_nxt = IDLE;
    end

    // Datapath: request captures, tweak register, whitening and block counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sector <= 128'h0;
            key1   <= 256'h0;
            key2   <= 256'h0;
            t      <= 128'h0;
            x      <= 128'h0;
            c      <= 128'h0;
            cnt    <= 16'h0;
        end else begin
            if ((state == IDLE) && i_start && !i_abort) begin
                sector <= i_sector;
                key1   <= i_key1;
                key2   <= i_key2;
                cnt    <= 16'h0;
            end
            if (twk_phase && i_core_valid) begin
                t <= i_core_data;
            end
            if ((state == BLK_IN) && i_blk_valid) begin
                x <= i_blk_data ^ t;
            end
            if (blk_phase && i_core_valid) begin
                c <= i_core_data ^ t;
            end
            if ((state == BLK_OUT) && i_blk_ready) begin
                t   <= mul_alpha(t);
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_serpent_xts_sector_ctrl.sv
// Bench for serpent_xts_sector_ctrl: core model (result = data ^ key[127:0], fixed latency) plus scoreboards.
// Expected core requests and ciphertexts are pushed by the stimulus; monitors pop on each DUT presentation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_serpent_xts_sector_ctrl;

    localparam int BPS = 2;
    localparam logic [127:0] HI1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    localparam logic [127:0] HI2 = 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_start = 1'b0;
    logic [127:0] i_sector = 128'h0;
    logic [255:0] i_key1 = 256'h0;
    logic [255:0] i_key2 = 256'h0;
    logic         i_abort = 1'b0;
    logic         o_busy;
    logic         o_sector_done;
    logic         i_blk_valid = 1'b0;
    logic         o_blk_ready;
    logic [127:0] i_blk_data = 128'h0;
    logic         o_blk_valid;
    logic         i_blk_ready = 1'b1;
    logic [127:0] o_blk_data;
    logic         o_core_key_valid;
    logic         o_core_enable;
    logic [255:0] o_core_key;
    logic [127:0] o_core_data;
    logic [127:0] i_core_data = 128'h0;
    logic         i_core_valid = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [127:0] exp_req_dat[$];
    logic [255:0] exp_req_key[$];
    logic [127:0] exp_ct[$];
    bit           exp_last[$];

    serpent_xts_sector_ctrl #(.BLOCKS_PER_SECTOR(BPS)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_sector(i_sector),
        .i_key1(i_key1), .i_key2(i_key2), .i_abort(i_abort), .o_busy(o_busy),
        .o_sector_done(o_sector_done), .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready),
        .i_blk_data(i_blk_data), .o_blk_valid(o_blk_valid), .i_blk_ready(i_blk_ready),
        .o_blk_data(o_blk_data), .o_core_key_valid(o_core_key_valid),
        .o_core_enable(o_core_enable), .o_core_key(o_core_key), .o_core_data(o_core_data),
        .i_core_data(i_core_data), .i_core_valid(i_core_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [127:0] dat, input logic [255:0] key);
        exp_req_dat.push_back(dat);
        exp_req_key.push_back(key);
    endtask

    task automatic push_ct(input logic [127:0] ct, input bit last);
        exp_ct.push_back(ct);
        exp_last.push_back(last);
    endtask

    // Core model: captures each new request, answers data ^ key[127:0] four edges later.
    bit         pend = 0;
    bit         issued = 0;
    int         lat = 0;
    logic [127:0] req_dat;
    logic [255:0] req_key;
    always @(negedge i_clk) begin
        i_core_valid = 1'b0;
        if (!i_rstn) begin
            pend   = 0;
            issued = 0;
        end else begin
            if (pend) begin
                if (lat == 0) begin
                    i_core_valid = 1'b1;
                    i_core_data  = req_dat ^ req_key[127:0];
                    pend         = 0;
                end else begin
                    lat--;
                end
            end else if (o_core_enable && !issued) begin
                issued  = 1;
                pend    = 1;
                lat     = 2;
                req_dat = o_core_data;
                req_key = o_core_key;
                chk("core_key_valid", {255'h0, o_core_key_valid}, 256'h1);
                if (exp_req_dat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL core_req unexpected: data %h", o_core_data);
                end else begin
                    chk("core_req_data", {128'h0, o_core_data}, {128'h0, exp_req_dat.pop_front()});
                    chk("core_req_key", o_core_key, exp_req_key.pop_front());
                end
            end
            if (!o_core_enable) issued = 0;
        end
    end

    // Output monitor: ciphertext scoreboard, done pulse timing, busy drop.
    bit done_due = 0;
    bit done_exp = 0;
    bit busy_due = 0;
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            done_due = 0;
            busy_due = 0;
        end else begin
            if (busy_due) begin
                chk("busy_after_done", {255'h0, o_busy}, 256'h0);
                busy_due = 0;
            end
            if (done_due) begin
                chk("sector_done", {255'h0, o_sector_done}, {255'h0, done_exp});
                if (o_sector_done) done_cnt++;
                busy_due = done_exp;
                done_due = 0;
            end else if (o_sector_done) begin
                checks++; errors++; done_cnt++;
                $display("FAIL spurious_done: got 1 want 0");
            end
            if (o_blk_valid && i_blk_ready) begin
                if (exp_ct.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ct unexpected: data %h", o_blk_data);
                end else begin
                    chk("ciphertext", {128'h0, o_blk_data}, {128'h0, exp_ct.pop_front()});
                    done_exp = exp_last.pop_front();
                    done_due = 1;
                end
            end
        end
    end

    task automatic start_sector(input logic [127:0] sec, input logic [127:0] k1lo, input logic [127:0] k2lo);
        @(posedge i_clk); #1;
        i_sector = sec;
        i_key1   = {HI1, k1lo};
        i_key2   = {HI2, k2lo};
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] p);
        bit ok = 0;
        @(posedge i_clk); #1;
        i_blk_valid = 1'b1;
        i_blk_data  = p;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clk);
            if (o_blk_ready) ok = 1;
        end
        @(posedge i_clk); #1;
        i_blk_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_block timeout: ready 0 want 1");
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge i_clk);
            if (!o_busy) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout: busy 1 want 0");
        end
    endtask

    task automatic wait_out_valid();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge i_clk);
            if (o_blk_valid) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_out_valid timeout: valid 0 want 1");
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {255'h0, o_busy}, 256'h0);
        chk({tag, "_blk_valid"}, {255'h0, o_blk_valid}, 256'h0);
        chk({tag, "_blk_ready"}, {255'h0, o_blk_ready}, 256'h0);
        chk({tag, "_blk_data"}, {128'h0, o_blk_data}, 256'h0);
        chk({tag, "_core_en"}, {254'h0, o_core_enable, o_core_key_valid}, 256'h0);
        chk({tag, "_core_key"}, o_core_key, 256'h0);
        chk({tag, "_core_data"}, {128'h0, o_core_data}, 256'h0);
        chk({tag, "_done"}, {255'h0, o_sector_done}, 256'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge i_clk);
        chk_outputs_zero("reset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk_outputs_zero("post_reset");

        // Test 1: T = 1; X = 1, 2; C = FF, FF.
        push_req(128'h1, {HI2, 128'h0});
        push_req(128'h1, {HI1, 128'hFF});
        push_req(128'h2, {HI1, 128'hFF});
        push_ct(128'hFF, 0);
        push_ct(128'hFF, 1);
        start_sector(128'h1, 128'hFF, 128'h0);
        @(negedge i_clk);
        chk("start_busy", {255'h0, o_busy}, 256'h1);
        chk("start_core_en", {255'h0, o_core_enable}, 256'h1);
        send_block(128'h0);
        send_block(128'h0);
        wait_idle();

        // Test 2: tweak MSB carry; second data request = 87.
        push_req(128'h8000_0000_0000_0000_0000_0000_0000_0000, {HI2, 128'h0});
        push_req(128'h8000_0000_0000_0000_0000_0000_0000_0000, {HI1, 128'hFF});
        push_req(128'h87, {HI1, 128'hFF});
        push_ct(128'hFF, 0);
        push_ct(128'hFF, 1);
        start_sector(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'hFF, 128'h0);
        send_block(128'h0);
        send_block(128'h0);
        wait_idle();

        // Tests 3+4: T = 2; P = A5 -> X = A7, C = 1291; T = 4; P = 5A -> X = 5E, C = 126E.
        push_req(128'h2, {HI2, 128'h0});
        push_req(128'hA7, {HI1, 128'h1234});
        push_req(128'h5E, {HI1, 128'h1234});
        push_ct(128'h1291, 0);
        push_ct(128'h126E, 1);
        i_blk_ready = 1'b0;
        start_sector(128'h2, 128'h1234, 128'h0);
        send_block(128'hA5);
        wait_out_valid();
        repeat (10) begin
            @(negedge i_clk);
            chk("bp_valid", {255'h0, o_blk_valid}, 256'h1);
            chk("bp_data", {128'h0, o_blk_data}, {128'h0, 128'h1291});
            chk("bp_core_en", {255'h0, o_core_enable}, 256'h0);
        end
        @(posedge i_clk); #1;
        i_blk_ready = 1'b1;
        @(posedge i_clk);
        repeat (20) begin
            @(negedge i_clk);
            chk("starve_core_en", {255'h0, o_core_enable}, 256'h0);
            chk("starve_ready", {255'h0, o_blk_ready}, 256'h1);
        end
        send_block(128'h5A);
        wait_idle();

        // Test 5: abort in BLK_WAIT of block 1 (T = 9, then 12).
        push_req(128'h9, {HI2, 128'h0});
        push_req(128'h9, {HI1, 128'hFF});
        push_req(128'h12, {HI1, 128'hFF});
        push_ct(128'hFF, 0);
        start_sector(128'h9, 128'hFF, 128'h0);
        send_block(128'h0);
        send_block(128'h0);
        @(posedge i_clk); #1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_busy", {255'h0, o_busy}, 256'h0);
        chk("abort_core_en", {255'h0, o_core_enable}, 256'h0);
        repeat (6) begin
            @(negedge i_clk);
            chk("stale_busy", {255'h0, o_busy}, 256'h0);
            chk("stale_out", {254'h0, o_blk_valid, o_blk_ready}, 256'h0);
        end
        // Restart: T = 3 ^ 5 = 6; X = 7, E; C = F1, F2.
        push_req(128'h3, {HI2, 128'h5});
        push_req(128'h7, {HI1, 128'hF0});
        push_req(128'hE, {HI1, 128'hF0});
        push_ct(128'hF1, 0);
        push_ct(128'hF2, 1);
        start_sector(128'h3, 128'hF0, 128'h5);
        send_block(128'h1);
        send_block(128'h2);
        wait_idle();

        // Test 6: async reset while holding a ciphertext in BLK_OUT.
        push_req(128'h1, {HI2, 128'h0});
        push_req(128'h1, {HI1, 128'hFF});
        i_blk_ready = 1'b0;
        start_sector(128'h1, 128'hFF, 128'h0);
        send_block(128'h0);
        wait_out_valid();
        @(posedge i_clk); #3;
        i_rstn = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        @(posedge i_clk); #1;
        i_rstn      = 1'b1;
        i_blk_ready = 1'b1;
        i_blk_valid = 1'b1;
        i_blk_data  = 128'h0;
        repeat (5) begin
            @(negedge i_clk);
            chk("rst_idle_busy", {255'h0, o_busy}, 256'h0);
            chk("rst_idle_ready", {255'h0, o_blk_ready}, 256'h0);
            chk("rst_idle_core_en", {255'h0, o_core_enable}, 256'h0);
        end
        @(posedge i_clk); #1;
        i_blk_valid = 1'b0;
        repeat (3) @(negedge i_clk);

        chk("left_core_reqs", 256'(exp_req_dat.size()), 256'h0);
        chk("left_ciphertexts", 256'(exp_ct.size()), 256'h0);
        chk("done_pulses", 256'(done_cnt), 256'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serpent_xts_sector_ctrl.md
# serpent_xts_sector_ctrl

Sequencer that drives one shared Serpent encryption core (256-bit key, 128-bit block, `serpent_en_top` port semantics) through a full XTS-mode sector encrypt. On `i_start`, it encrypts the sector number under the tweak key K2 to form the initial tweak. It then streams `BLOCKS_PER_SECTOR` plaintext blocks through the core under the data key K1, applying the XTS pre- and post-whitening and advancing the tweak by α after each block. It sits between the storage-side block stream and the core. This version covers the encrypt direction only and does not handle ciphertext stealing.

## Interface
Parameters:
- `BLOCKS_PER_SECTOR`, default 32: 128-bit blocks per sector (512-byte sector). Legal range 1..65535.

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: single-cycle start pulse. Accepted only in IDLE.
- `i_sector`, in, 128: sector number, sampled on an accepted `i_start`.
- `i_key1`, in, 256: data key. `i_key2`, in, 256: tweak key. Both sampled on an accepted `i_start`.
- `i_abort`, in, 1: synchronous abort. Returns the block to IDLE.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_sector_done`, out, 1: one-cycle pulse after the last ciphertext block is accepted downstream.
- `i_blk_valid`, in, 1 / `o_blk_ready`, out, 1 / `i_blk_data`, in, 128: plaintext input handshake.
- `o_blk_valid`, out, 1 / `i_blk_ready`, in, 1 / `o_blk_data`, out, 128: ciphertext output handshake.
- `o_core_key_valid`, out, 1 / `o_core_enable`, out, 1 / `o_core_key`, out, 256 / `o_core_data`, out, 128: requests to the core.
- `i_core_data`, in, 128 / `i_core_valid`, in, 1: core result. `i_core_valid` is a single-cycle pulse and core latency is variable.

## Operation
- States: IDLE, TWK_REQ, TWK_WAIT, BLK_IN, BLK_REQ, BLK_WAIT, BLK_OUT, DONE.
- IDLE:
  - `i_start` latches the sector, key1 and key2, clears the block counter, and moves to TWK_REQ.
  - `i_start` is ignored in every other state.
- TWK_REQ and TWK_WAIT:
  - Core is driven with `o_core_key`=K2, `o_core_data`=sector, and `o_core_key_valid`=`o_core_enable`=1.
  - These outputs are held steady until `i_core_valid`, then the result is latched into tweak register T and the state moves to BLK_IN.
- BLK_IN:
  - `o_blk_ready`=1.
  - On `i_blk_valid`&&`o_blk_ready`, latch X = `i_blk_data` ^ T and move to BLK_REQ.
- BLK_REQ and BLK_WAIT:
  - Core is driven with K1 and X, enables held until `i_core_valid`.
  - On `i_core_valid`, latch C = `i_core_data` ^ T and move to BLK_OUT.
- BLK_OUT:
  - `o_blk_valid`=1, `o_blk_data`=C, held stable until `i_blk_ready`.
  - On the transfer, T ← mulα(T) and the counter increments.
  - If the counter reaches `BLOCKS_PER_SECTOR`, go to DONE; otherwise go to BLK_IN.
- DONE: pulse `o_sector_done` for one cycle, then go to IDLE.
- mulα (IEEE 1619, little-endian bytes, byte k = T[8k+7:8k]):
  - T' = {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0).
- Counter width is 16 bits. The compare is against `BLOCKS_PER_SECTOR`; there is no wrap within a sector.
- Key switching: `o_core_key_valid` is asserted with every request, so the core re-expands its key on each request. The key source switches from K2 to K1 only after the tweak result has been latched.
- `i_abort`:
  - In any non-IDLE state, the next state is IDLE and all enables and valids drop.
  - A pending core result is ignored: `i_core_valid` seen in IDLE is discarded.
  - `o_sector_done` is not pulsed.
- `i_abort` and `i_start` in the same cycle in IDLE: abort wins and the start is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, T=0, counter=0.
- `i_start` accepted at edge n: `o_busy` and the core enables are high from n+1.
- Core result at edge m (`i_core_valid` high): enables drop at m+1.
  - For the tweak, `o_blk_ready` is high at m+1.
  - For a data block, `o_blk_valid` is high at m+1.
- Plaintext accepted at edge p: the core request is issued at p+1.
- Enable drop: `o_core_enable` is low for at least one cycle between consecutive requests, at the BLK_IN/BLK_OUT boundaries.
- Last ciphertext accepted at edge q: `o_sector_done` is high during cycle q+1 and `o_busy` is low from q+2.
- Overhead per block, excluding core latency, is 3 cycles with no backpressure.
- The block never has more than one core request outstanding.

## Test plan
The bench uses a core model with result = data ^ key[127:0] and fixed latency 4 cycles.

1. **Tweak.** K2[127:0]=128'h0, sector=128'h1, `BLOCKS_PER_SECTOR`=2, K1[127:0]=128'hFF, plaintext blocks 0 and 0.
   - Core data requests seen: 1 (key K2), then 1 (key K1), then 2.
   - Ciphertext out: FF, FF.
   - One `o_sector_done` pulse.
2. **Tweak carry.** sector=128'h8000_0000_0000_0000_0000_0000_0000_0000, K2 low=0, 2 blocks of zeros.
   - Second data request to the core = 128'h87.
3. **Backpressure.** Hold `i_blk_ready`=0 for 10 cycles in BLK_OUT.
   - `o_blk_data` stable, `o_blk_valid` held high, no T update and no new core request until the transfer.
4. **Starved input.** `i_blk_valid`=0 for 20 cycles mid-sector.
   - `o_core_enable` stays low and the counter is unchanged.
5. **Abort.** `i_abort` during BLK_WAIT of block 1.
   - Next cycle: IDLE, `o_busy`=0, no `o_sector_done`.
   - The stale `i_core_valid` that follows is ignored.
   - A new `i_start` then runs a full correct sector.
6. **Async reset mid-sector.** Deassert `i_rstn` asynchronously in BLK_OUT.
   - All outputs 0 immediately. After release, the block is in IDLE and ignores input until `i_start`.
